// File: rtl/tx_data_feeder.sv
// Host-side character FIFO feeding the SpaceWire transmit FSM's ping-pong data slots in strict write order.
// Optional end-of-packet counter on tx_eop_count is built only when TX_DATA_FEEDER_EOP_COUNT_EN is defined.
module tx_data_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          pclk_tx,
  input  logic          rst_tx,
  input  logic [8:0]    data_tx_i,
  input  logic          txwrite_tx,
  output logic          txrdy_tx,
  input  logic [6:0]    state_tx,
  input  logic          ready_tx_data,
  output logic [8:0]    tx_data_in,
  output logic          process_data,
  output logic [8:0]    tx_data_in_0,
  output logic          process_data_0,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    tx_eop_count
);

  localparam logic [6:0]  DATA_C     = 7'b0010000;
  localparam logic [6:0]  DATA_C_0   = 7'b0100000;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_PROMOTE,
    ACT_LOAD0,
    ACT_LOAD1
  } slotAction_t;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_readyD;
  logic [8:0]    r_slot0;
  logic [8:0]    r_slot1;
  logic          r_valid0;
  logic          r_valid1;

  logic          w_inDataC;
  logic          w_inDataC0;
  logic          w_take;
  logic          w_wrEn;
  logic          w_pop;
  logic          w_fifoNotEmpty;
  logic [8:0]    w_head;
  slotAction_t   w_action;

  assign w_inDataC      = (state_tx == DATA_C);
  assign w_inDataC0     = (state_tx == DATA_C_0);
  assign w_take         = ready_tx_data & ~r_readyD;
  assign w_fifoNotEmpty = (r_level != '0);
  assign w_wrEn         = txwrite_tx & txrdy_tx;
  assign w_head         = r_mem[r_rptr];
  assign w_pop          = (w_action == ACT_LOAD0) || (w_action == ACT_LOAD1);

  assign txrdy_tx       = (r_level != FULL_LEVEL);
  assign fifo_level     = r_level;
  assign tx_data_in     = r_slot0;
  assign process_data   = r_valid0;
  assign tx_data_in_0   = r_slot1;
  assign process_data_0 = r_valid1;

  // Slots never change while the FSM sits in their data state; slot0 always holds the older character.
  always_comb begin
    w_action = ACT_NONE;
    if (!r_valid0 && r_valid1 && !w_inDataC && !w_inDataC0) begin
      w_action = ACT_PROMOTE;
    end else if (w_fifoNotEmpty && !r_valid0 && !r_valid1 && !w_inDataC) begin
      w_action = ACT_LOAD0;
    end else if (w_fifoNotEmpty && r_valid0 && !r_valid1 && !w_inDataC && !w_inDataC0) begin
      w_action = ACT_LOAD1;
    end
  end

  always_ff @(posedge pclk_tx) begin
    if (w_wrEn) begin
      r_mem[r_wptr] <= data_tx_i;
    end
  end

  always_ff @(posedge pclk_tx or posedge rst_tx) begin
    if (rst_tx) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_readyD <= 1'b0;
    end else begin
      r_readyD <= ready_tx_data;
      if (w_wrEn) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wrEn && !w_pop) begin
        r_level <= r_level + (AW + 1)'(1);
      end else if (!w_wrEn && w_pop) begin
        r_level <= r_level - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge pclk_tx or posedge rst_tx) begin
    if (rst_tx) begin
      r_slot0  <= '0;
      r_slot1  <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
    end else begin
      if (w_take && w_inDataC) begin
        r_valid0 <= 1'b0;
      end
      if (w_take && w_inDataC0) begin
        r_valid1 <= 1'b0;
      end
      case (w_action)
        ACT_PROMOTE: begin
          r_slot0  <= r_slot1;
          r_valid0 <= 1'b1;
          r_valid1 <= 1'b0;
        end
        ACT_LOAD0: begin
          r_slot0  <= w_head;
          r_valid0 <= 1'b1;
        end
        ACT_LOAD1: begin
          r_slot1  <= w_head;
          r_valid1 <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TX_DATA_FEEDER_EOP_COUNT_EN
  logic [7:0] r_eopCount;
  logic       w_eopTake;

  // EOP is 9'h100 and EEP is 9'h101: control flag set and bit 1 clear.
  assign w_eopTake = w_take &&
                     ((w_inDataC  && r_slot0[8] && !r_slot0[1]) ||
                      (w_inDataC0 && r_slot1[8] && !r_slot1[1]));

  always_ff @(posedge pclk_tx or posedge rst_tx) begin
    if (rst_tx) begin
      r_eopCount <= 8'd0;
    end else if (w_eopTake) begin
      r_eopCount <= r_eopCount + 8'd1;
    end
  end

  assign tx_eop_count = r_eopCount;
`else
  assign tx_eop_count = 8'd0;
`endif

endmodule
